uart_rx_byte: RTL
=================

Name: uart_rx_byte

Overview:
- Serial UART receiver, 8N1 format, LSB first.
- Sits directly upstream of `verify`: converts the asynchronous serial line into `ascii_char` / `char_valid` strobes.
- Sampling is mid-bit, driven by a divide counter derived from `freq / UART_RX_BAUD`.
- Flags framing errors and blocks on a held-low line (break) until the line returns to idle.

Parameters:
- UART_RX_BAUD, 20: receive baud rate, same units as `freq`.
- freq, 200: system clock frequency. CLKS_PER_BIT = freq/UART_RX_BAUD (default 10).
- Elaboration error if CLKS_PER_BIT < 4.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- ascii_char  output  8  last correctly framed byte; held until the next good byte.
- char_valid  output  1  one-cycle pulse when `ascii_char` is updated.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - synchronizer flops = 1; FSM = IDLE; counters = 0; shift register = 0.
  - ascii_char = 0x00; char_valid = 0; frame_error = 0; busy = 0.
- Synchronizer:
  - rx passes through 2 flops to give rx_s, so 2 cycles of latency.
  - All FSM decisions use rx_s only.
- Counters:
  - bit_cnt runs 0..CLKS_PER_BIT-1.
  - bit_idx runs 0..7.
  - HALF = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s=0, go to START and set bit_cnt=0.
  - START: bit_cnt increments. At bit_cnt==HALF-1:
    - rx_s=0: go to DATA, bit_cnt=0, bit_idx=0.
    - rx_s=1: glitch, return to IDLE with no outputs.
  - DATA: at bit_cnt==CLKS_PER_BIT-1:
    - shift rx_s into the MSB of the shift register (right shift), so the first bit received lands at bit 0;
    - bit_cnt=0;
    - if bit_idx==7 go to STOP, else bit_idx+1.
  - STOP: at bit_cnt==CLKS_PER_BIT-1:
    - rx_s=1: ascii_char <= shift register, char_valid=1 for exactly that next cycle, go to IDLE.
    - rx_s=0: frame_error=1 for one cycle, ascii_char unchanged, go to BREAK.
  - BREAK: stay until rx_s=1, then go to IDLE. Low time in BREAK never starts a frame.
- Timing:
  - char_valid rises ≈ 9.5·CLKS_PER_BIT + 3 cycles after the start-bit falling edge on rx.
  - char_valid and frame_error are never high in the same cycle.
- Back-to-back frames:
  - A start bit whose falling edge arrives immediately after the stop-bit sample is accepted.
  - IDLE checks rx_s on the cycle after the STOP exit.
- Byte 0x00 is a legal byte and is delivered with char_valid, since `verify` uses it as a delimiter.
- Reset asserted mid-frame:
  - immediate return to reset values;
  - the partial byte is discarded;
  - no strobe is emitted after release.
- Outputs are registered, with no combinational path from rx.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, BREAK);
  - DATA_BITS = 8;
  - function clks_per_bit(freq, baud).
- Sub-module sync_2ff: 2-flop synchronizer with a reset value parameter (1 here). Reusable by a future uart_tx / rx pair.

Test Plan:
1. Send 0x41 ('A') at 10 clk/bit → exactly one char_valid pulse, ascii_char=0x41, frame_error never high, busy low afterwards.
2. Send "\0","1","A","2","B",…,"\0" with no idle gap between frames → 10 char_valid pulses in order 0x00,0x31,0x41,0x32,0x42,…,0x00. Feeding these into `verify` asserts sequence_valid for "1A2B3C4D" and not for "1X2Y3Z4W".
3. Drive a 3-cycle low glitch on idle rx → no char_valid, no frame_error; FSM back in IDLE within HALF+3 cycles.
4. Send 0x55 with a low stop bit, holding rx low for 30 cycles afterwards → one frame_error pulse, ascii_char keeps its prior value, no new frame during the low time. A subsequent 0x33 is received correctly.
5. Assert rst low in the middle of data bit 4 of 0xA5, release, then send 0x5A → no strobe for the aborted byte; one char_valid with 0x5A.
6. Parameter sweep: freq=200, UART_RX_BAUD=40 (CLKS_PER_BIT=5) with bit edges skewed by ±1 cycle → bytes 0xFF, 0x00, 0x81 all received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the receive path (and a future transmitter).
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    // Number of payload bits per 8N1 frame.
    localparam int DATA_BITS = 8;

    // Receiver framing states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // System clocks spent on one bit on the line.
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous levels into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running level path.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling, framing-error flag, blocks while the line is held low.
// Latency: char_valid about 9.5*CLKS_PER_BIT + 3 cycles after the start-bit falling edge.
// Backpressure: none; char_valid/frame_error are single-cycle strobes the consumer must take.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int UART_RX_BAUD = 20,
    parameter int freq         = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] ascii_char,
    output logic                 char_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(freq, UART_RX_BAUD);
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // Fewer than 4 clocks per bit leaves no margin around the mid-bit sample.
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_divider
            $error("uart_rx_byte: freq / UART_RX_BAUD must be at least 4");
        end
    endgenerate

    logic                 rx_s;
    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_nxt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic [DATA_BITS-1:0] char_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Register FSM state, counters, shift register and all outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            ascii_char  <= '0;
            char_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shreg       <= shreg_nxt;
            ascii_char  <= char_nxt;
            char_valid  <= valid_nxt;
            frame_error <= ferr_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

    // Next-state, counter and strobe logic; every decision looks only at rx_s.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        char_nxt    = ascii_char;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = START;
                end
            end

            // Re-check the start bit half a bit in; a high level there was a glitch.
            START: begin
                if (bit_cnt == CNT_MID) begin
                    bit_cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_ONE;
                end
            end

            // Right shift so the first (LSB) bit ends up at bit 0 after eight samples.
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_nxt = '0;
                    shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_ONE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_ONE;
                end
            end

            // Exiting at mid stop bit lets a back-to-back start edge be caught on time.
            STOP: begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt_nxt = '0;
                    if (rx_s) begin
                        char_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = BREAK;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + CNT_ONE;
                end
            end

            // A held-low line must return high before another frame can start.
            BREAK: begin
                bit_cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt   = IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
    end

endmodule
